// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable controller with wake settle, round-robin grant and idle linger.
// Optional scan override of CLK_EN via TEST_MODE when CLK_GATE_CTRL_DFT_EN is defined.
module clk_gate_ctrl #(
  parameter int NUM_REQ  = 4,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 4
) (
  input  logic               CLK,
  input  logic               RST,
`ifdef CLK_GATE_CTRL_DFT_EN
  input  logic               TEST_MODE,
`endif
  input  logic [NUM_REQ-1:0] REQ,
  output logic [NUM_REQ-1:0] GNT,
  output logic               CLK_EN,
  output logic               BUSY
);

  localparam int MAXC = (WAKE_CYC > IDLE_CYC) ? WAKE_CYC : IDLE_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int PW   = $clog2(NUM_REQ);

  localparam logic [CW-1:0] WAKE_LD = CW'(WAKE_CYC - 1);
  localparam logic [CW-1:0] IDLE_LD = CW'(IDLE_CYC - 1);
  localparam logic [PW-1:0] LAST    = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    OFF,
    WAKE,
    GRANT,
    LINGER
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 en_q, en_d;

  logic [NUM_REQ-1:0]   cand;
  logic [NUM_REQ-1:0]   win_oh;
  logic [PW-1:0]        win_idx;
  logic [PW-1:0]        ptr_nxt;
  logic                 found;
  int                   j;

  // A releasing owner is masked out so it competes only from the next edge.
  always_comb begin
    cand    = (state_q == GRANT) ? (REQ & ~gnt_q) : REQ;
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && cand[j]) begin
        found      = 1'b1;
        win_oh[j]  = 1'b1;
        win_idx    = PW'(j);
      end
    end
    ptr_nxt = (win_idx == LAST) ? '0 : win_idx + PW'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    en_d    = en_q;
    unique case (state_q)
      OFF: begin
        gnt_d = '0;
        en_d  = 1'b0;
        if (|REQ) begin
          state_d = WAKE;
          en_d    = 1'b1;
          cnt_d   = WAKE_LD;
        end
      end
      WAKE: begin
        en_d  = 1'b1;
        gnt_d = '0;
        if (cnt_q == '0) begin
          if (found) begin
            state_d = GRANT;
            gnt_d   = win_oh;
            ptr_d   = ptr_nxt;
          end else begin
            state_d = LINGER;
            cnt_d   = IDLE_LD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GRANT: begin
        en_d = 1'b1;
        if (|(REQ & gnt_q)) begin
          gnt_d = gnt_q;
        end else if (found) begin
          gnt_d = win_oh;
          ptr_d = ptr_nxt;
        end else begin
          state_d = LINGER;
          gnt_d   = '0;
          cnt_d   = IDLE_LD;
        end
      end
      LINGER: begin
        en_d  = 1'b1;
        gnt_d = '0;
        if (found) begin
          state_d = GRANT;
          gnt_d   = win_oh;
          ptr_d   = ptr_nxt;
        end else if (cnt_q == '0) begin
          state_d = OFF;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = OFF;
        gnt_d   = '0;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= OFF;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      en_q    <= en_d;
    end
  end

  assign GNT  = gnt_q;
  assign BUSY = (state_q != OFF);

`ifdef CLK_GATE_CTRL_DFT_EN
  assign CLK_EN = en_q | TEST_MODE;
`else
  assign CLK_EN = en_q;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl (NUM_REQ=4, WAKE_CYC=2, IDLE_CYC=4).
// Expected outputs are queued per step and checked #1 after the edge.
module tb_clk_gate_ctrl;

  typedef struct {
    logic [3:0] gnt;
    logic       en;
    logic       busy;
    string      tag;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] REQ = '0;
  logic [3:0] GNT;
  logic       CLK_EN;
  logic       BUSY;
`ifdef CLK_GATE_CTRL_DFT_EN
  logic       TEST_MODE = 1'b0;
`endif

  int   tests  = 0;
  int   fails  = 0;
  exp_t q[$];

  clk_gate_ctrl #(
    .NUM_REQ (4),
    .WAKE_CYC(2),
    .IDLE_CYC(4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
`ifdef CLK_GATE_CTRL_DFT_EN
    .TEST_MODE(TEST_MODE),
`endif
    .REQ      (REQ),
    .GNT      (GNT),
    .CLK_EN   (CLK_EN),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic compare();
    exp_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty got=0 exp=1");
      return;
    end
    e = q.pop_front();
    tests++;
    assert (GNT === e.gnt) else begin
      fails++;
      $error("FAIL %s.gnt got=%b exp=%b", e.tag, GNT, e.gnt);
    end
    tests++;
    assert (CLK_EN === e.en) else begin
      fails++;
      $error("FAIL %s.clk_en got=%b exp=%b", e.tag, CLK_EN, e.en);
    end
    tests++;
    assert (BUSY === e.busy) else begin
      fails++;
      $error("FAIL %s.busy got=%b exp=%b", e.tag, BUSY, e.busy);
    end
    tests++;
    assert ($onehot0(GNT) && !((GNT != 4'b0) && !CLK_EN)) else begin
      fails++;
      $error("FAIL %s.invariant gnt=%b clk_en=%b", e.tag, GNT, CLK_EN);
    end
  endtask

  // Drive REQ, expect the given outputs after the next rising edge.
  task automatic step(input logic [3:0] r, input logic [3:0] g,
                      input logic en, input logic b, input string t);
    exp_t e;
    REQ = r;
    e.gnt = g; e.en = en; e.busy = b; e.tag = t;
    q.push_back(e);
    @(posedge CLK);
    #1;
    compare();
  endtask

  initial begin
    // Reset
    RST = 1'b1;
    step(4'b0000, 4'b0000, 1'b0, 1'b0, "reset");
    RST = 1'b0;

    // 1: wake then first grant two edges after CLK_EN rises
    step(4'b0001, 4'b0000, 1'b1, 1'b1, "wake_e0");
    step(4'b0001, 4'b0000, 1'b1, 1'b1, "wake_e1");
    for (int i = 2; i < 10; i++)
      step(4'b0001, 4'b0001, 1'b1, 1'b1, $sformatf("hold_e%0d", i));

    // 2: release, linger IDLE_CYC edges, then off
    step(4'b0000, 4'b0000, 1'b1, 1'b1, "rel_e10");
    for (int i = 11; i < 14; i++)
      step(4'b0000, 4'b0000, 1'b1, 1'b1, $sformatf("linger_e%0d", i));
    step(4'b0000, 4'b0000, 1'b0, 1'b0, "off_e14");

    // 3: rotation with zero-gap handover (ptr reset first)
    RST = 1'b1;
    step(4'b1111, 4'b0000, 1'b0, 1'b0, "reset2");
    RST = 1'b0;
    step(4'b1111, 4'b0000, 1'b1, 1'b1, "rr_wake0");
    step(4'b1111, 4'b0000, 1'b1, 1'b1, "rr_wake1");
    step(4'b1111, 4'b0001, 1'b1, 1'b1, "rr_g0a");
    step(4'b1111, 4'b0001, 1'b1, 1'b1, "rr_g0b");
    step(4'b1111, 4'b0001, 1'b1, 1'b1, "rr_g0c");
    step(4'b1110, 4'b0010, 1'b1, 1'b1, "rr_g1a");
    step(4'b1111, 4'b0010, 1'b1, 1'b1, "rr_g1b");
    step(4'b1111, 4'b0010, 1'b1, 1'b1, "rr_g1c");
    step(4'b1101, 4'b0100, 1'b1, 1'b1, "rr_g2a");
    step(4'b1111, 4'b0100, 1'b1, 1'b1, "rr_g2b");
    step(4'b1111, 4'b0100, 1'b1, 1'b1, "rr_g2c");
    step(4'b1011, 4'b1000, 1'b1, 1'b1, "rr_g3a");
    step(4'b1111, 4'b1000, 1'b1, 1'b1, "rr_g3b");
    step(4'b1111, 4'b1000, 1'b1, 1'b1, "rr_g3c");
    step(4'b0111, 4'b0001, 1'b1, 1'b1, "rr_wrap");
    step(4'b0001, 4'b0001, 1'b1, 1'b1, "rr_hold");

    // 4: new request inside linger grants without re-wake
    step(4'b0000, 4'b0000, 1'b1, 1'b1, "lg_enter");
    step(4'b0000, 4'b0000, 1'b1, 1'b1, "lg_1");
    step(4'b0100, 4'b0100, 1'b1, 1'b1, "lg_grant");
    step(4'b0100, 4'b0100, 1'b1, 1'b1, "lg_hold");

    // Requests from others ignored while owner holds; unheld ones are lost
    step(4'b0010, 4'b0010, 1'b1, 1'b1, "handover");
    step(4'b0110, 4'b0010, 1'b1, 1'b1, "ignore");
    step(4'b0010, 4'b0010, 1'b1, 1'b1, "ignore2");

    // 5: mid-grant reset then ptr restarts at 0
    RST = 1'b1;
    step(4'b0010, 4'b0000, 1'b0, 1'b0, "rst_mid");
    RST = 1'b0;
    step(4'b0011, 4'b0000, 1'b1, 1'b1, "re_wake0");
    step(4'b0011, 4'b0000, 1'b1, 1'b1, "re_wake1");
    step(4'b0011, 4'b0001, 1'b1, 1'b1, "ptr_reset");
    step(4'b0010, 4'b0010, 1'b1, 1'b1, "next_1");
    step(4'b0000, 4'b0000, 1'b1, 1'b1, "lg2_enter");
    step(4'b0010, 4'b0010, 1'b1, 1'b1, "sole_regrant");
    step(4'b0000, 4'b0000, 1'b1, 1'b1, "lg3_enter");
    for (int i = 1; i < 4; i++)
      step(4'b0000, 4'b0000, 1'b1, 1'b1, $sformatf("lg3_%0d", i));
    step(4'b0000, 4'b0000, 1'b0, 1'b0, "off2");

    // WAKE with request gone at counter expiry goes to linger
    step(4'b1000, 4'b0000, 1'b1, 1'b1, "wk_only0");
    step(4'b0000, 4'b0000, 1'b1, 1'b1, "wk_only1");
    step(4'b0000, 4'b0000, 1'b1, 1'b1, "wk_linger");

`ifdef CLK_GATE_CTRL_DFT_EN
    // 6: scan override
    RST = 1'b1;
    step(4'b0000, 4'b0000, 1'b0, 1'b0, "dft_rst");
    RST = 1'b0;
    begin
      exp_t e;
      TEST_MODE = 1'b1;
      #1;
      e.gnt = 4'b0000; e.en = 1'b1; e.busy = 1'b0; e.tag = "dft_on";
      q.push_back(e);
      compare();
      step(4'b0000, 4'b0000, 1'b1, 1'b0, "dft_on_edge");
      TEST_MODE = 1'b0;
      #1;
      e.gnt = 4'b0000; e.en = 1'b0; e.busy = 1'b0; e.tag = "dft_off";
      q.push_back(e);
      compare();
    end
`endif

    tests++;
    assert (q.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain got=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
